// File: rtl/channel_pkg.sv
// Shared definitions for the program input/output channel blocks.
package channel_pkg;

  localparam int MemoryElementWidth = 12;

  typedef logic [MemoryElementWidth-1:0] word_t;

  // Circular pointer increment for depths that need not be a power of two.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/channel_ram.sv
// Channel word storage: one synchronous write port, one asynchronous read port.
module channel_ram #(
  parameter int Width = 12,
  parameter int Depth = 100,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_channel_reader.sv
// Buffers words from the program's out instruction and streams them to the host
// over valid/ready; a full buffer drops new words and flags overflow.
module out_channel_reader #(
  parameter int MemoryElementWidth = channel_pkg::MemoryElementWidth,
  parameter int NOut = 100,
  localparam int CntW = $clog2(NOut + 1),
  localparam int PtrW = $clog2(NOut)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  input  logic                          finished,
  output logic                          rd_valid,
  output logic [MemoryElementWidth-1:0] rd_data,
  input  logic                          rd_ready,
  output logic [CntW-1:0]               count,
  output logic [15:0]                   total,
  output logic                          overflow,
  output logic                          drained
);

  import channel_pkg::*;

  logic [PtrW-1:0] wp, rp;
  logic [CntW-1:0] cnt;
  logic [15:0]     tot;
  logic            ovf;
  logic            finished_seen;
  logic            rd_fire;
  logic            accept;

  assign rd_fire = (cnt != '0) && rd_ready;
  // A read in the same cycle frees the slot, so a full buffer can still accept.
  assign accept  = out_valid && ((cnt < CntW'(NOut)) || rd_fire);

  always_ff @(posedge clock) begin
    if (reset) begin
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
      tot           <= '0;
      ovf           <= 1'b0;
      finished_seen <= 1'b0;
    end else begin
      if (accept) begin
        wp <= PtrW'(ptr_next(32'(wp), NOut));
        if (tot != 16'hFFFF) tot <= tot + 16'd1;
      end else if (out_valid) begin
        ovf <= 1'b1;
      end
      if (rd_fire) rp <= PtrW'(ptr_next(32'(rp), NOut));
      case ({accept, rd_fire})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
      if (finished) finished_seen <= 1'b1;
    end
  end

  channel_ram #(
    .Width(MemoryElementWidth),
    .Depth(NOut)
  ) u_ram (
    .clock(clock),
    .we   (accept && !reset),
    .waddr(wp),
    .wdata(out_data),
    .raddr(rp),
    .rdata(rd_data)
  );

  assign rd_valid = (cnt != '0);
  assign count    = cnt;
  assign total    = tot;
  assign overflow = ovf;
  assign drained  = finished_seen && (cnt == '0) && !out_valid;

endmodule

// File: tb/tb_out_channel_reader.sv
// Scoreboard bench: three readers (depth 100, 4, 3) against a queue-based model.
module tb_out_channel_reader;
  import channel_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nd [3] = '{100, 4, 3};

  logic        rst [3];
  logic        ov  [3];
  logic [11:0] od  [3];
  logic        fin [3];
  logic        rr  [3];
  logic        rv  [3];
  logic [11:0] rd  [3];
  logic [15:0] tot [3];
  logic        ovf [3];
  logic        drn [3];
  logic [6:0]  cnt0;
  logic [2:0]  cnt1;
  logic [1:0]  cnt2;

  out_channel_reader #(.MemoryElementWidth(12), .NOut(100)) u0 (
    .clock(clk), .reset(rst[0]), .out_valid(ov[0]), .out_data(od[0]), .finished(fin[0]),
    .rd_valid(rv[0]), .rd_data(rd[0]), .rd_ready(rr[0]), .count(cnt0), .total(tot[0]),
    .overflow(ovf[0]), .drained(drn[0]));
  out_channel_reader #(.MemoryElementWidth(12), .NOut(4)) u1 (
    .clock(clk), .reset(rst[1]), .out_valid(ov[1]), .out_data(od[1]), .finished(fin[1]),
    .rd_valid(rv[1]), .rd_data(rd[1]), .rd_ready(rr[1]), .count(cnt1), .total(tot[1]),
    .overflow(ovf[1]), .drained(drn[1]));
  out_channel_reader #(.MemoryElementWidth(12), .NOut(3)) u2 (
    .clock(clk), .reset(rst[2]), .out_valid(ov[2]), .out_data(od[2]), .finished(fin[2]),
    .rd_valid(rv[2]), .rd_data(rd[2]), .rd_ready(rr[2]), .count(cnt2), .total(tot[2]),
    .overflow(ovf[2]), .drained(drn[2]));

  // Reference model: buffered words live in a queue; the rest is plain counters.
  word_t q0[$], q1[$], q2[$];
  int    mcount [3];
  int    mtotal [3];
  bit    movf   [3];
  bit    mfs    [3];
  bit    mon_en = 1'b0;
  int    n_chk  = 0;
  int    n_pass = 0;

  function automatic int dcount(int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic void qpush(int i, word_t w);
    case (i)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endfunction

  function automatic int qsize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic word_t qpop(int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qclear(int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic check(string name, int i, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s [dut%0d]: got %0d, expected %0d", name, i, act, exp);
  endtask

  function automatic void model_step(int i);
    bit fire, acc;
    if (rst[i]) begin
      mcount[i] = 0; mtotal[i] = 0; movf[i] = 1'b0; mfs[i] = 1'b0;
      qclear(i);
    end else begin
      fire = (mcount[i] != 0) && rr[i];
      acc  = ov[i] && (mcount[i] < nd[i] || fire);
      if (acc) begin
        qpush(i, od[i]);
        if (mtotal[i] < 65535) mtotal[i]++;
      end else if (ov[i]) begin
        movf[i] = 1'b1;
      end
      mcount[i] = mcount[i] + int'(acc) - int'(fire);
      if (fin[i]) mfs[i] = 1'b1;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
  endtask

  task automatic drain(int i, string name);
    rr[i] = 1'b1;
    for (int t = 0; t < 300 && rv[i]; t++) cyc();
    check(name, i, int'(rv[i]), 0);
    rr[i] = 1'b0;
  endtask

  // Monitor: compares status outputs every cycle and pops the scoreboard on each read.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        check("rd_valid", i, int'(rv[i]), int'(mcount[i] != 0));
        check("count", i, dcount(i), mcount[i]);
        check("total", i, int'(tot[i]), mtotal[i]);
        check("overflow", i, int'(ovf[i]), int'(movf[i]));
        check("drained", i, int'(drn[i]), int'(mfs[i] && mcount[i] == 0 && !ov[i]));
        if (rv[i] && rr[i]) begin
          if (qsize(i) == 0) check("read_underrun", i, qsize(i), 1);
          else check("rd_data", i, int'(rd[i]), int'(qpop(i)));
        end
      end
    end
  end

  int prog [9] = '{1, 2, 3, 3, 33, 2, 22, 1, 11};

  initial begin
    int k, prev;
    bit tog;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; ov[i] = 1'b0; od[i] = '0; fin[i] = 1'b0; rr[i] = 1'b0;
    end
    cyc();
    mon_en = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    cyc();

    // Program stream, then finish and drain.
    foreach (prog[j]) begin
      ov[0] = 1'b1; od[0] = 12'(prog[j]); cyc();
    end
    ov[0] = 1'b0; fin[0] = 1'b1;
    drain(0, "prog_empty");
    check("prog_total", 0, int'(tot[0]), 9);
    check("prog_drained", 0, int'(drn[0]), 1);
    check("prog_overflow", 0, int'(ovf[0]), 0);
    check("prog_all_read", 0, qsize(0), 0);

    // Empty-buffer write latency.
    ov[0] = 1'b1; od[0] = 12'd5;
    check("lat_before", 0, int'(rv[0]), 0);
    cyc();
    ov[0] = 1'b0;
    check("lat_valid", 0, int'(rv[0]), 1);
    check("lat_data", 0, int'(rd[0]), 5);
    drain(0, "lat_empty");

    // Full buffer drops the fifth word.
    for (int v = 10; v <= 14; v++) begin
      ov[1] = 1'b1; od[1] = 12'(v); cyc();
    end
    ov[1] = 1'b0;
    check("full_count", 1, int'(cnt1), 4);
    check("full_overflow", 1, int'(ovf[1]), 1);
    check("full_total", 1, int'(tot[1]), 4);
    drain(1, "full_empty");

    // Full buffer with a read in the same cycle accepts the write.
    rst[1] = 1'b1; cyc(); rst[1] = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      ov[1] = 1'b1; od[1] = 12'(v); cyc();
    end
    od[1] = 12'd5; rr[1] = 1'b1; cyc();
    ov[1] = 1'b0; rr[1] = 1'b0;
    check("fullrd_overflow", 1, int'(ovf[1]), 0);
    check("fullrd_count", 1, int'(cnt1), 4);
    check("fullrd_head", 1, int'(rd[1]), 2);
    drain(1, "fullrd_empty");

    // Wrap on depth 3 with alternating reads; dropped words are re-offered.
    k = 0; tog = 1'b1;
    for (int t = 0; t < 400 && k < 20; t++) begin
      ov[2] = 1'b1; od[2] = 12'(100 + k); rr[2] = tog;
      prev = mtotal[2];
      cyc();
      if (mtotal[2] != prev) k++;
      tog = !tog;
    end
    ov[2] = 1'b0;
    drain(2, "wrap_empty");
    check("wrap_total", 2, int'(tot[2]), 20);
    check("wrap_all_read", 2, qsize(2), 0);

    // Reset mid-stream together with a write.
    rst[0] = 1'b1; cyc(); rst[0] = 1'b0;
    for (int v = 0; v < 3; v++) begin
      ov[0] = 1'b1; od[0] = 12'(60 + v); cyc();
    end
    rst[0] = 1'b1; od[0] = 12'd777; cyc();
    rst[0] = 1'b0; ov[0] = 1'b0;
    check("rst_count", 0, int'(cnt0), 0);
    check("rst_valid", 0, int'(rv[0]), 0);
    check("rst_total", 0, int'(tot[0]), 0);
    ov[0] = 1'b1; od[0] = 12'd42; cyc();
    ov[0] = 1'b0;
    check("rst_next_word", 0, int'(rd[0]), 42);
    drain(0, "rst_empty");

    // Random traffic on all three readers.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 3; i++) begin
        ov[i]  = ($urandom_range(0, 2) != 0);
        od[i]  = 12'($urandom);
        rr[i]  = ($urandom_range(0, 1) != 0);
        fin[i] = fin[i] | ($urandom_range(0, 63) == 0);
        rst[i] = ($urandom_range(0, 399) == 0);
      end
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      ov[i] = 1'b0; rst[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) drain(i, "rand_empty");
    cyc();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
